// File: rtl/dmem_resp.sv
// MEM-stage data memory: byte-enabled RAM with combinational loads, sticky misalignment flag.
// Define DMEM_MMIO_EN to add the MMIO window (64-bit timer, tohost mailbox, status register).
module dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwriteM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    input  logic [31:0] pcM,
    input  logic [1:0]  lwhbM,
    input  logic [1:0]  swhbM,
    input  logic        luM,
    output logic [31:0] rdataM,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        misalign_err,
    output logic [31:0] misalign_pc
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          st_mis, ld_mis, acc_mis;
    logic          is_mmio, ram_we;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   rword, ram_rd, mmio_rd;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic          misalign_err_q, misalign_err_d;

    function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b01:   is_mis = lo[0];
            2'b10:   is_mis = 1'b0;
            default: is_mis = (lo != 2'b00);
        endcase
    endfunction

    assign idx     = addrM[AW+1:2];
    assign lane    = addrM[1:0];
    assign st_mis  = is_mis(swhbM, lane);
    assign ld_mis  = is_mis(lwhbM, lane);
    assign acc_mis = memwriteM ? st_mis : ld_mis;

`ifdef DMEM_MMIO_EN
    logic [63:0] mtime_q, mtime_d;
    logic [31:0] tohost_data_q, tohost_data_d;
    logic        tohost_valid_q, tohost_valid_d;
    logic [31:0] misalign_pc_q, misalign_pc_d;
    logic        mmio_wr;

    assign is_mmio = (addrM[31:16] == MMIO_BASE[31:16]);
    // Sub-word MMIO stores are dropped; misaligned ones are already suppressed.
    assign mmio_wr = memwriteM && is_mmio && !st_mis && (swhbM == 2'b00 || swhbM == 2'b11);

    always_comb begin
        mmio_rd = 32'b0;
        case (addrM[15:0])
            16'h0000: mmio_rd = mtime_q[31:0];
            16'h0004: mmio_rd = mtime_q[63:32];
            16'h0008: mmio_rd = tohost_data_q;
            16'h000C: mmio_rd = {30'b0, tohost_valid_q, misalign_err_q};
            default:  mmio_rd = 32'b0;
        endcase
    end
`else
    logic unused_bits;
    assign unused_bits = ^{addrM[31:AW+2], pcM};
    assign is_mmio     = 1'b0;
    assign mmio_rd     = 32'b0;
`endif

    // Store lane steering
    always_comb begin
        be     = 4'b1111;
        wlanes = wdataM;
        case (swhbM)
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdataM[15:0]}};
            end
            2'b10: begin
                be     = 4'b0001 << lane;
                wlanes = {4{wdataM[7:0]}};
            end
            default: ;
        endcase
    end

    assign ram_we = memwriteM && !st_mis && !is_mmio;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    // Load lane select and extension
    always_comb begin
        rword  = mem[idx];
        rbyte  = rword[{lane, 3'b000} +: 8];
        rhalf  = rword[{lane[1], 4'b0000} +: 16];
        ram_rd = rword;
        case (lwhbM)
            2'b01:   ram_rd = luM ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            2'b10:   ram_rd = luM ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            default: ram_rd = rword;
        endcase
        rdataM = ram_rd;
        if (ld_mis) begin
            rdataM = 32'b0;
        end else if (is_mmio) begin
            rdataM = (lwhbM == 2'b00 || lwhbM == 2'b11) ? mmio_rd : 32'b0;
        end
    end

    // Register next-state; sets are applied after clears so set wins
    always_comb begin
        misalign_err_d = misalign_err_q;
`ifdef DMEM_MMIO_EN
        mtime_d        = mtime_q + 64'd1;
        tohost_data_d  = tohost_data_q;
        tohost_valid_d = tohost_valid_q;
        misalign_pc_d  = misalign_pc_q;
        if (mmio_wr) begin
            case (addrM[15:0])
                16'h0000: mtime_d = {mtime_q[63:32], wdataM};
                16'h0004: mtime_d = {wdataM, mtime_q[31:0]};
                16'h0008: begin
                    tohost_data_d  = wdataM;
                    tohost_valid_d = 1'b1;
                end
                16'h000C: begin
                    if (wdataM[0]) misalign_err_d = 1'b0;
                    if (wdataM[1]) tohost_valid_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (acc_mis && !misalign_err_q) misalign_pc_d = pcM;
`endif
        if (acc_mis) misalign_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_err_q <= 1'b0;
`ifdef DMEM_MMIO_EN
            mtime_q        <= 64'd0;
            tohost_data_q  <= 32'd0;
            tohost_valid_q <= 1'b0;
            misalign_pc_q  <= 32'd0;
`endif
        end else begin
            misalign_err_q <= misalign_err_d;
`ifdef DMEM_MMIO_EN
            mtime_q        <= mtime_d;
            tohost_data_q  <= tohost_data_d;
            tohost_valid_q <= tohost_valid_d;
            misalign_pc_q  <= misalign_pc_d;
`endif
        end
    end

    assign misalign_err = misalign_err_q;
`ifdef DMEM_MMIO_EN
    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign misalign_pc  = misalign_pc_q;
`else
    assign tohost_valid = 1'b0;
    assign tohost_data  = 32'b0;
    assign misalign_pc  = 32'b0;
`endif

endmodule
